// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

  localparam int unsigned MD_DEF_WIDTH      = 32;
  localparam int unsigned MD_DEF_MUL_CYCLES = 5;
  localparam int unsigned MD_DEF_DIV_CYCLES = 10;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       mdOp;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             abort;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdOp, operand1, operand2, abort,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdOp, operand1, operand2, abort,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide datapath.
module md_arith #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               div_zero
);

  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  // Sign-magnitude division; the most-negative / -1 case wraps back to the
  // most-negative value with zero remainder without special handling.
  always_comb begin
    a_neg    = is_signed & a[WIDTH-1];
    b_neg    = is_signed & b[WIDTH-1];
    a_ext    = {{WIDTH{a_neg}}, a};
    b_ext    = {{WIDTH{b_neg}}, b};
    prod     = a_ext * b_ext;
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = (b == '0);
    b_safe   = div_zero ? WIDTH'(1) : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
    if (div_zero) begin
      quot = '0;
      rem  = '0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH      = MD_DEF_WIDTH,
  parameter int unsigned MUL_CYCLES = MD_DEF_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = MD_DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  md_unit_if.slave   bus
);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_we;

  md_op_e             op;
  logic               is_signed;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;

  assign op        = md_op_e'(bus.mdOp);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .a        (bus.operand1),
    .b        (bus.operand2),
    .is_signed(is_signed),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  // Request acceptance, latency countdown and HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend_hi <= prod[2*WIDTH-1:WIDTH];
                pend_lo <= prod[WIDTH-1:0];
                pend_we <= 1'b1;
                cnt     <= CW'(MUL_CYCLES);
                busy_q  <= 1'b1;
                state   <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= rem;
                pend_lo <= quot;
                pend_we <= !div_zero;
                cnt     <= CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state   <= ST_RUN;
              end
              OP_MTHI: hi_q <= bus.operand1;
              OP_MTLO: lo_q <= bus.operand1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (cnt == CW'(1)) begin
            if (pend_we) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built on native SV arithmetic.
  function automatic exp_t model(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sbv;
    e.tag = tag; e.hi = m_hi; e.lo = m_lo; e.cyc = 0;
    sa = a; sbv = b;
    case (op)
      3'd0: begin
        sp = longint'(sa) * longint'(sbv);
        up = sp;
        e.hi = up[63:32]; e.lo = up[31:0]; e.cyc = 5;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        e.hi = up[63:32]; e.lo = up[31:0]; e.cyc = 5;
      end
      3'd2: begin
        e.cyc = 10;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'h0;
          end else begin
            e.lo = sa / sbv; e.hi = sa % sbv;
          end
        end
      end
      3'd3: begin
        e.cyc = 10;
        if (b != 0) begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Issue one request, wait (bounded) for busy to drop, then score it.
  task automatic issue(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int unsigned n;
    sb.push_back(model(tag, op, a, b));
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = op; bus.operand1 = a; bus.operand2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    chk({e.tag, ".busy_cycles"}, 64'(n), 64'(e.cyc));
    chk({e.tag, ".hi"}, 64'(bus.hi), 64'(e.hi));
    chk({e.tag, ".lo"}, 64'(bus.lo), 64'(e.lo));
    m_hi = e.hi; m_lo = e.lo;
  endtask

  initial begin
    bus.start = 1'b0; bus.mdOp = '0; bus.operand1 = '0; bus.operand2 = '0; bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.hi", 64'(bus.hi), 64'd0);
    chk("reset.lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a multiply
    issue("mthi_pre", 3'd4, 32'h99, 32'h0);
    issue("mtlo_pre", 3'd5, 32'h98, 32'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = 3'd0; bus.operand1 = 32'd7; bus.operand2 = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.hi", 64'(bus.hi), 64'd0);
    chk("rst_mid.lo", 64'(bus.lo), 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_late.busy", 64'(bus.busy), 64'd0);
    chk("rst_late.hi", 64'(bus.hi), 64'd0);
    chk("rst_late.lo", 64'(bus.lo), 64'd0);

    // Multiply / divide
    issue("mult_neg", 3'd0, 32'hFFFF_FFFF, 32'd2);
    issue("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
    issue("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    issue("divu", 3'd3, 32'd7, 32'd2);
    issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("mult_rand", 3'd0, 32'h1234_5678, 32'h8765_4321);
    issue("div_rand", 3'd2, 32'h7654_3210, 32'hFFFF_FF00);

    // Divide by zero keeps HI/LO
    issue("dz_mthi", 3'd4, 32'h11, 32'h0);
    issue("dz_mtlo", 3'd5, 32'h22, 32'h0);
    issue("divu_zero", 3'd3, 32'd5, 32'd0);
    issue("rsv6", 3'd6, 32'hDEAD, 32'hBEEF);

    // Abort mid-run with an ignored MTLO
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = 3'd0; bus.operand1 = 32'd3; bus.operand2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = 3'd5; bus.operand1 = 32'h55;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort.busy_before", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy_after", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort.hi", 64'(bus.hi), 64'(m_hi));
    chk("abort.lo", 64'(bus.lo), 64'(m_lo));
    chk("abort.busy_idle", 64'(bus.busy), 64'd0);

    // Abort coinciding with the completion edge
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = 3'd0; bus.operand1 = 32'd4; bus.operand2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_done.busy_before", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done.busy", 64'(bus.busy), 64'd0);
    chk("abort_done.hi", 64'(bus.hi), 64'(m_hi));
    chk("abort_done.lo", 64'(bus.lo), 64'(m_lo));

    // Abort together with start in IDLE drops the request
    @(negedge clk);
    bus.abort = 1'b1; bus.start = 1'b1; bus.mdOp = 3'd4; bus.operand1 = 32'h77;
    @(posedge clk);
    #1;
    chk("idle_abort.mthi", 64'(bus.hi), 64'(m_hi));
    @(negedge clk);
    bus.mdOp = 3'd0; bus.operand1 = 32'd9; bus.operand2 = 32'd9;
    @(posedge clk);
    #1;
    chk("idle_abort.busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;

    // Back-to-back
    issue("b2b_multu", 3'd1, 32'd2, 32'd3);
    issue("b2b_divu", 3'd3, 32'd9, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
